// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator: each word request becomes four little-endian byte accesses; owns the stack pointer.
// Optional stack bounds checking is enabled by defining MEM_STACK_GUARD_EN.
module mem_access_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int STACK_TOP   = 1024,
    parameter int STACK_LIMIT = 768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_opcode,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_data,
    output logic [31:0]       resp_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [ADDR_W:0]   sp_out
);

    localparam int SP_W = ADDR_W + 1;

    localparam logic [5:0] OP_LW    = 6'b000011;
    localparam logic [5:0] OP_LWPOI = 6'b000100;
    localparam logic [5:0] OP_SW    = 6'b000110;
    localparam logic [5:0] OP_PUSH  = 6'b001111;
    localparam logic [5:0] OP_POP   = 6'b010000;

    // state | meaning
    // IDLE  | waiting for a request, response fields cleared
    // ISSUE | byte k of the word on the memory port
    // DRAIN | read only: last byte returning from memory
    // RESP  | resp_valid high for one cycle
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t            state;
    logic [1:0]        k;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata_q;
    logic [23:0]       rbuf;
    logic [31:0]       resp_addr_q;
    logic              op_read;
    logic              op_pop;

    logic              is_mem_op;
    logic              is_push;
    logic              is_pop;
    logic              known;
    logic              range_bad;
    logic              guard_bad;
    logic              req_err;
    logic [SP_W-1:0]   end_addr;
    logic [SP_W-1:0]   sp_minus4;
    logic [SP_W-1:0]   acc_base;
    logic [31:0]       acc_resp_addr;
    logic              active;

    assign sp_out    = sp;
    assign sp_minus4 = sp - SP_W'(4);

    always_comb begin
        is_mem_op = (req_opcode == OP_LW) || (req_opcode == OP_LWPOI) || (req_opcode == OP_SW);
        is_push   = (req_opcode == OP_PUSH);
        is_pop    = (req_opcode == OP_POP);
        known     = is_mem_op || is_push || is_pop;
        end_addr  = {1'b0, req_addr[ADDR_W-1:0]} + SP_W'(3);
        range_bad = (|req_addr[31:ADDR_W]) || end_addr[ADDR_W];
`ifdef MEM_STACK_GUARD_EN
        guard_bad = (is_push && (32'(sp) < 32'(STACK_LIMIT + 4))) ||
                    (is_pop && (32'(sp) + 32'd4 > 32'(STACK_TOP)));
`else
        guard_bad = 1'b0;
`endif
        req_err = !known || (is_mem_op && range_bad) || guard_bad;

        acc_base = {1'b0, req_addr[ADDR_W-1:0]};
        if (is_push)
            acc_base = sp_minus4;
        else if (is_pop)
            acc_base = sp;

        acc_resp_addr = req_addr;
        if (req_opcode == OP_LWPOI)
            acc_resp_addr = req_addr + 32'd4;
        else if (is_push || is_pop)
            acc_resp_addr = 32'(acc_base);
    end

    // Memory port is combinational so the burst has no bubbles; reset silences it at once.
    always_comb begin
        active    = (state == ISSUE) && rst_n;
        mem_en    = active;
        mem_we    = active && !op_read;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (active) begin
            mem_addr = base + ADDR_W'(k);
            if (!op_read)
                mem_wdata = wdata_q[{k, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= 2'd0;
            sp          <= SP_W'(STACK_TOP);
            base        <= '0;
            wdata_q     <= 32'h0;
            rbuf        <= 24'h0;
            resp_addr_q <= 32'h0;
            op_read     <= 1'b0;
            op_pop      <= 1'b0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_data   <= 32'h0;
            resp_addr   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        k           <= 2'd0;
                        rbuf        <= 24'h0;
                        base        <= acc_base[ADDR_W-1:0];
                        wdata_q     <= req_data;
                        resp_addr_q <= acc_resp_addr;
                        op_read     <= (req_opcode == OP_LW) || (req_opcode == OP_LWPOI) || is_pop;
                        op_pop      <= is_pop;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_addr  <= acc_resp_addr;
                        end else begin
                            state <= ISSUE;
                            if (is_push)
                                sp <= sp_minus4;
                        end
                    end
                end
                ISSUE: begin
                    // Byte issued last cycle is on mem_rdata now.
                    if (op_read) begin
                        case (k)
                            2'd1:    rbuf[7:0]   <= mem_rdata;
                            2'd2:    rbuf[15:8]  <= mem_rdata;
                            2'd3:    rbuf[23:16] <= mem_rdata;
                            default: ;
                        endcase
                    end
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        if (op_read) begin
                            state <= DRAIN;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_addr  <= resp_addr_q;
                        end
                    end
                end
                DRAIN: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= {mem_rdata, rbuf};
                    resp_addr  <= resp_addr_q;
                    if (op_pop)
                        sp <= sp + SP_W'(4);
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_data  <= 32'h0;
                    resp_addr  <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
